// File: rtl/zap_interrupt_controller.sv
// ZAP interrupt controller: synchronises IRQ/FIQ, masks with CPSR,
// arbitrates FIQ over IRQ and presents a held request until acked.
module zap_interrupt_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 2,
  parameter bit IRQ_EDGE    = 1'b0,
  parameter int CNT_WDT     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_irq_async,
  input  logic               i_fiq_async,
  input  logic [31:0]        i_cpsr,
  input  logic               i_fiq_ack,
  input  logic               i_irq_ack,
  output logic               o_fiq,
  output logic               o_irq,
  output logic [CNT_WDT-1:0] o_fiq_cnt,
  output logic [CNT_WDT-1:0] o_irq_cnt,
  output logic               o_spurious_ack
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIQ,
    IRQ,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] fiq_sync_q, fiq_sync_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic                   irq_dly_q, irq_dly_d;
  logic                   irq_pend_q, irq_pend_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [CNT_WDT-1:0]     fiq_cnt_q, fiq_cnt_d;
  logic [CNT_WDT-1:0]     irq_cnt_q, irq_cnt_d;
  logic                   spur_q, spur_d;
  logic                   o_fiq_q, o_fiq_d;
  logic                   o_irq_q, o_irq_d;

  logic fiq_s, irq_s, irq_rise;
  logic fiq_req, irq_req;
  logic fiq_ack_ok, irq_ack_ok;
  logic unused_cpsr;

  assign unused_cpsr = ^{i_cpsr[31:8], i_cpsr[5:0]};

  assign fiq_s    = fiq_sync_q[SYNC_STAGES-1];
  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign irq_rise = irq_s & ~irq_dly_q;

  assign fiq_req = fiq_s & ~i_cpsr[6];
  assign irq_req = (IRQ_EDGE ? irq_pend_q : irq_s) & ~i_cpsr[7];

  assign fiq_ack_ok = i_fiq_ack & (state_q == FIQ);
  assign irq_ack_ok = i_irq_ack & (state_q == IRQ);

  always_comb begin
    fiq_sync_d = {fiq_sync_q[SYNC_STAGES-2:0], i_fiq_async};
    irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], i_irq_async};
    irq_dly_d  = irq_s;
    irq_pend_d = irq_pend_q;
    if (irq_ack_ok) irq_pend_d = 1'b0;
    if (irq_rise)   irq_pend_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    fiq_cnt_d = fiq_cnt_q;
    irq_cnt_d = irq_cnt_q;
    spur_d    = spur_q
              | (i_fiq_ack & ~fiq_ack_ok)
              | (i_irq_ack & ~irq_ack_ok);
    unique case (state_q)
      IDLE: begin
        if (fiq_req)      state_d = FIQ;
        else if (irq_req) state_d = IRQ;
      end
      FIQ: begin
        if (i_fiq_ack) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          if (fiq_cnt_q != '1)
            fiq_cnt_d = fiq_cnt_q + CNT_WDT'(1);
        end else if (!fiq_req) begin
          state_d = IDLE;
        end
      end
      IRQ: begin
        if (i_irq_ack) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          if (irq_cnt_q != '1)
            irq_cnt_d = irq_cnt_q + CNT_WDT'(1);
        end else if (fiq_req) begin
          state_d = FIQ;
        end else if (!irq_req) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        // last hold cycle arbitrates like IDLE so the window is HOLDOFF cycles
        if (hold_q != '0)  hold_d  = hold_q - HW'(1);
        else if (fiq_req)  state_d = FIQ;
        else if (irq_req)  state_d = IRQ;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    o_fiq_d = (state_d == FIQ);
    o_irq_d = (state_d == IRQ);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      fiq_sync_q <= '0;
      irq_sync_q <= '0;
      irq_dly_q  <= 1'b0;
      irq_pend_q <= 1'b0;
      hold_q     <= '0;
      fiq_cnt_q  <= '0;
      irq_cnt_q  <= '0;
      spur_q     <= 1'b0;
      o_fiq_q    <= 1'b0;
      o_irq_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fiq_sync_q <= fiq_sync_d;
      irq_sync_q <= irq_sync_d;
      irq_dly_q  <= irq_dly_d;
      irq_pend_q <= irq_pend_d;
      hold_q     <= hold_d;
      fiq_cnt_q  <= fiq_cnt_d;
      irq_cnt_q  <= irq_cnt_d;
      spur_q     <= spur_d;
      o_fiq_q    <= o_fiq_d;
      o_irq_q    <= o_irq_d;
    end
  end

  assign o_fiq          = o_fiq_q;
  assign o_irq          = o_irq_q;
  assign o_fiq_cnt      = fiq_cnt_q;
  assign o_irq_cnt      = irq_cnt_q;
  assign o_spurious_ack = spur_q;

endmodule

// File: tb/tb_zap_interrupt_controller.sv
// Bench for zap_interrupt_controller: directed steps plus random traffic
// against a cycle-level behavioural model (level, edge, narrow-counter DUTs).
module tb_zap_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_in = 1'b0;
  logic        fiq_in = 1'b0;
  logic        fack = 1'b0;
  logic        iack = 1'b0;
  logic [31:0] cpsr = 32'h0;

  logic        l_fiq, l_irq, l_spur;
  logic [15:0] l_fcnt, l_icnt;
  logic        e_fiq, e_irq, e_spur;
  logic [15:0] e_fcnt, e_icnt;
  logic        s_fiq, s_irq, s_spur;
  logic [3:0]  s_fcnt, s_icnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  zap_interrupt_controller #(.IRQ_EDGE(1'b0)) dut_l (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_irq_async(irq_in), .i_fiq_async(fiq_in), .i_cpsr(cpsr),
    .i_fiq_ack(fack), .i_irq_ack(iack),
    .o_fiq(l_fiq), .o_irq(l_irq),
    .o_fiq_cnt(l_fcnt), .o_irq_cnt(l_icnt),
    .o_spurious_ack(l_spur));

  zap_interrupt_controller #(.IRQ_EDGE(1'b1)) dut_e (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_irq_async(irq_in), .i_fiq_async(fiq_in), .i_cpsr(cpsr),
    .i_fiq_ack(fack), .i_irq_ack(iack),
    .o_fiq(e_fiq), .o_irq(e_irq),
    .o_fiq_cnt(e_fcnt), .o_irq_cnt(e_icnt),
    .o_spurious_ack(e_spur));

  zap_interrupt_controller #(.CNT_WDT(4)) dut_s (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_irq_async(irq_in), .i_fiq_async(fiq_in), .i_cpsr(cpsr),
    .i_fiq_ack(fack), .i_irq_ack(iack),
    .o_fiq(s_fiq), .o_irq(s_irq),
    .o_fiq_cnt(s_fcnt), .o_irq_cnt(s_icnt),
    .o_spurious_ack(s_spur));

  // model: index 0 = level IRQ, 1 = edge IRQ; who: 0 none, 1 fiq, 2 irq
  bit qf[$];
  bit qi[$];
  bit prev_is;
  bit pend;
  int who[2];
  int quiet[2];
  int cf[2];
  int ci[2];
  bit spur[2];

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    qf = {1'b0, 1'b0};
    qi = {1'b0, 1'b0};
    prev_is = 1'b0;
    pend = 1'b0;
    for (int m = 0; m < 2; m++) begin
      who[m] = 0; quiet[m] = 0;
      cf[m] = 0; ci[m] = 0; spur[m] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit fs, is, rise, fr, ir;
    int w;
    fs = qf.pop_front(); qf.push_back(fiq_in);
    is = qi.pop_front(); qi.push_back(irq_in);
    rise = is && !prev_is;
    prev_is = is;
    for (int m = 0; m < 2; m++) begin
      fr = fs && !cpsr[6];
      ir = ((m == 1) ? pend : is) && !cpsr[7];
      w = who[m];
      if ((fack && w != 1) || (iack && w != 2)) spur[m] = 1'b1;
      if (m == 1) begin
        if (iack && w == 2) pend = 1'b0;
        if (rise) pend = 1'b1;
      end
      if (quiet[m] > 0) begin
        quiet[m]--;
        if (quiet[m] == 0) who[m] = fr ? 1 : (ir ? 2 : 0);
      end else if (w == 1) begin
        if (fack) begin cf[m]++; quiet[m] = 2; who[m] = 0; end
        else if (!fr) who[m] = 0;
      end else if (w == 2) begin
        if (iack) begin ci[m]++; quiet[m] = 2; who[m] = 0; end
        else if (fr) who[m] = 1;
        else if (!ir) who[m] = 0;
      end else begin
        who[m] = fr ? 1 : (ir ? 2 : 0);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("l_fiq",  l_fiq,  who[0] == 1);
    chk("l_irq",  l_irq,  who[0] == 2);
    chk("l_fcnt", l_fcnt, sat(cf[0], 65535));
    chk("l_icnt", l_icnt, sat(ci[0], 65535));
    chk("l_spur", l_spur, spur[0]);
    chk("e_fiq",  e_fiq,  who[1] == 1);
    chk("e_irq",  e_irq,  who[1] == 2);
    chk("e_fcnt", e_fcnt, sat(cf[1], 65535));
    chk("e_icnt", e_icnt, sat(ci[1], 65535));
    chk("e_spur", e_spur, spur[1]);
    chk("s_fiq",  s_fiq,  who[0] == 1);
    chk("s_irq",  s_irq,  who[0] == 2);
    chk("s_fcnt", s_fcnt, sat(cf[0], 15));
    chk("s_icnt", s_icnt, sat(ci[0], 15));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int wt;
    model_reset();
    ticks(2);
    chk("rst_fiq", l_fiq, 0);
    chk("rst_cnt", l_icnt, 0);
    rst_n = 1'b1;

    // fiq latency, ack and hold-off
    cpsr = 32'h13; fiq_in = 1'b1;
    ticks(2);
    chk("t1_early", l_fiq, 0);
    tick();
    chk("t1_lat", l_fiq, 1);
    fack = 1'b1; tick(); fack = 1'b0;
    chk("t1_drop", l_fiq, 0);
    chk("t1_cnt", l_fcnt, 1);
    tick();
    chk("t1_hold", l_fiq, 0);
    tick();
    chk("t1_again", l_fiq, 1);
    fiq_in = 1'b0;
    ticks(4);
    chk("t1_wdraw", l_fiq, 0);

    // masked irq then unmask
    cpsr = 32'h93; irq_in = 1'b1;
    ticks(5);
    chk("t2_mask", l_irq, 0);
    cpsr = 32'h13;
    tick();
    chk("t2_unmask", l_irq, 1);
    chk("t2_edge", e_irq, 1);

    // fiq preempts irq
    fiq_in = 1'b1;
    ticks(2);
    chk("t3_pre_irq", l_irq, 1);
    tick();
    chk("t3_pre_irq0", l_irq, 0);
    chk("t3_pre_fiq1", l_fiq, 1);
    fack = 1'b1; tick(); fack = 1'b0;
    fiq_in = 1'b0;
    ticks(6);
    chk("t3_irq_back", l_irq, 1);
    // irq ack in the preempt cycle wins
    fiq_in = 1'b1;
    ticks(2);
    iack = 1'b1; tick(); iack = 1'b0;
    chk("t3_ack_fiq", l_fiq, 0);
    chk("t3_ack_irq", l_irq, 0);
    chk("t3_icnt", l_icnt, 1);
    ticks(2);
    chk("t3_fiq_after", l_fiq, 1);
    fack = 1'b1; tick(); fack = 1'b0;
    fiq_in = 1'b0; irq_in = 1'b0;
    ticks(8);
    chk("t3_idle_f", l_fiq, 0);
    chk("t3_idle_i", l_irq, 0);

    // edge irq pulse held while masked
    cpsr = 32'h93; irq_in = 1'b1;
    tick();
    irq_in = 1'b0;
    ticks(6);
    chk("t4_held", e_irq, 0);
    cpsr = 32'h13;
    tick();
    chk("t4_edge_irq", e_irq, 1);
    chk("t4_level_irq", l_irq, 0);
    chk("t5_no_spur", l_spur, 0);
    iack = 1'b1; tick(); iack = 1'b0;
    chk("t4_ack", e_irq, 0);
    chk("t4_ecnt", e_icnt, 2);
    ticks(4);
    chk("t4_cleared", e_irq, 0);

    // spurious ack is sticky
    chk("t5_spur", l_spur, 1);
    chk("t5_icnt", l_icnt, 1);
    ticks(5);
    chk("t5_sticky", l_spur, 1);
    rst_n = 1'b0;
    ticks(2);
    chk("t5_rst", l_spur, 0);
    rst_n = 1'b1;

    // async reset mid-fiq
    fiq_in = 1'b1;
    ticks(3);
    chk("t6_fiq", l_fiq, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", l_fiq, 0);
    ticks(2);
    rst_n = 1'b1;
    fiq_in = 1'b0;

    // counter saturation on the narrow instance
    irq_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wt = 0;
      while (who[0] != 2 && wt < 12) begin
        tick();
        wt++;
      end
      if (wt >= 12) chk("sat_wait", 0, 1);
      iack = 1'b1; tick(); iack = 1'b0;
    end
    ticks(3);
    chk("sat_narrow", s_icnt, 15);
    chk("sat_wide", l_icnt, 20);
    irq_in = 1'b0;
    ticks(6);

    // random traffic
    for (int n = 0; n < 2400; n++) begin
      if ($urandom_range(7) == 0) irq_in = ~irq_in;
      if ($urandom_range(9) == 0) fiq_in = ~fiq_in;
      cpsr = ($urandom() & 32'hFFFF_FF3F) | (cpsr & 32'hC0);
      if ($urandom_range(5) == 0) cpsr[7] = ~cpsr[7];
      if ($urandom_range(5) == 0) cpsr[6] = ~cpsr[6];
      fack = ((who[0] == 1) && ($urandom_range(2) == 0))
           || ($urandom_range(49) == 0);
      iack = ((who[0] == 2) && ($urandom_range(2) == 0))
           || ($urandom_range(49) == 0);
      rst_n = !(n == 1200);
      tick();
    end
    fack = 1'b0; iack = 1'b0; rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
